// File: rtl/z8_io_defs_pkg.sv
// Shared Z8 I/O definitions: debounce state encodings and board-input defaults.
package z8_io_defs;

    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_t;

    localparam int   DEFAULT_DEBOUNCE_TICKS = 8;
    localparam logic BTN_IDLE_LEVEL         = 1'b1;

endpackage

// File: rtl/port_input_conditioner_debounce_bit.sv
// Single-bit input conditioner: 2-flop synchronizer, tick-paced debouncer, edge pulses.
// PORT_INPUT_RISE_IRQ_EN adds the registered rise pulse output.
module debounce_bit
    import z8_io_defs::*;
#(
    parameter int   DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
    parameter logic IDLE_LEVEL     = BTN_IDLE_LEVEL
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic fall,
`ifdef PORT_INPUT_RISE_IRQ_EN
    output logic rise,
`endif
    output logic change
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_TICKS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_prev;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;
    db_state_t        r_state;
    logic             w_differ;
    logic             w_commit;

    assign w_differ = (r_s2 != r_stable);
    assign w_commit = w_differ && tick && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= IDLE_LEVEL;
            r_s2 <= IDLE_LEVEL;
        end else begin
            r_s1 <= pin;
            r_s2 <= r_s1;
        end
    end

    // The cycle that first sees the new level already counts as a tick, giving
    // DEBOUNCE_TICKS+2 clocks from pin edge to accepted level at tick=1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= DB_STABLE;
            r_cnt    <= '0;
            r_stable <= IDLE_LEVEL;
        end else begin
            case (r_state)
                DB_STABLE: begin
                    if (w_differ) begin
                        if (w_commit) begin
                            r_stable <= r_s2;
                        end else begin
                            r_state <= DB_PENDING;
                            r_cnt   <= tick ? CNT_ONE : '0;
                        end
                    end
                end
                DB_PENDING: begin
                    if (!w_differ) begin
                        r_state <= DB_STABLE;
                        r_cnt   <= '0;
                    end else if (w_commit) begin
                        r_stable <= r_s2;
                        r_cnt    <= '0;
                        r_state  <= DB_STABLE;
                    end else if (tick) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_state <= DB_STABLE;
            endcase
        end
    end

`ifdef PORT_INPUT_RISE_IRQ_EN
    logic r_rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= IDLE_LEVEL;
            r_fall <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= r_stable;
            r_fall <= r_prev & ~r_stable;
            r_rise <= ~r_prev & r_stable;
        end
    end

    assign rise   = r_rise;
    assign change = r_fall | r_rise;
`else
    logic r_chg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= IDLE_LEVEL;
            r_fall <= 1'b0;
            r_chg  <= 1'b0;
        end else begin
            r_prev <= r_stable;
            r_fall <= r_prev & ~r_stable;
            r_chg  <= r_prev ^ r_stable;
        end
    end

    assign change = r_chg;
`endif

    assign level = r_stable;
    assign fall  = r_fall;

endmodule

// File: rtl/port_input_conditioner.sv
// Board push-button/switch conditioner feeding the Z8 port3 input and its IRQ lines.
// PORT_INPUT_RISE_IRQ_EN adds the irq_rise output.
module port_input_conditioner
    import z8_io_defs::*;
#(
    parameter int   WIDTH          = 4,
    parameter int   DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
    parameter logic IDLE_LEVEL     = BTN_IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] port_in,
    output logic [WIDTH-1:0] irq_fall,
`ifdef PORT_INPUT_RISE_IRQ_EN
    output logic [WIDTH-1:0] irq_rise,
`endif
    output logic             changed
);

    logic [WIDTH-1:0] w_change;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .IDLE_LEVEL    (IDLE_LEVEL)
        ) u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .tick   (tick),
            .pin    (pins[i]),
            .level  (port_in[i]),
            .fall   (irq_fall[i]),
`ifdef PORT_INPUT_RISE_IRQ_EN
            .rise   (irq_rise[i]),
`endif
            .change (w_change[i])
        );
    end

    assign changed = |w_change;

endmodule

// File: tb/tb_port_input_conditioner.sv
// Scoreboarded bench for port_input_conditioner (DEBOUNCE_TICKS=4 with tick=1, DEBOUNCE_TICKS=3 with tick every 10th clk).
module tb_port_input_conditioner;

    localparam int W = 4;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         tick4   = 1'b1;
    logic         tick3   = 1'b0;
    logic [W-1:0] pins    = '0;
    logic [W-1:0] port_in4, irq_fall4, port_in3, irq_fall3;
    logic         changed4, changed3;
`ifdef PORT_INPUT_RISE_IRQ_EN
    logic [W-1:0] irq_rise4, irq_rise3;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int tick_div = 0;

    always #5 clk = ~clk;

    port_input_conditioner #(.WIDTH(W), .DEBOUNCE_TICKS(4), .IDLE_LEVEL(1'b1)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick4),
        .pins    (pins),
        .port_in (port_in4),
        .irq_fall(irq_fall4),
`ifdef PORT_INPUT_RISE_IRQ_EN
        .irq_rise(irq_rise4),
`endif
        .changed (changed4)
    );

    port_input_conditioner #(.WIDTH(W), .DEBOUNCE_TICKS(3), .IDLE_LEVEL(1'b1)) u_dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick3),
        .pins    (pins),
        .port_in (port_in3),
        .irq_fall(irq_fall3),
`ifdef PORT_INPUT_RISE_IRQ_EN
        .irq_rise(irq_rise3),
`endif
        .changed (changed3)
    );

    typedef struct packed {
        logic [W-1:0] port_in;
        logic [W-1:0] fall;
        logic [W-1:0] rise;
        logic         chg;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];

    // Reference model state, index 0 = DEBOUNCE_TICKS 4, index 1 = DEBOUNCE_TICKS 3
    logic [W-1:0] m_s1[2], m_s2[2], m_stb[2], m_fpend[2], m_rpend[2], m_fall[2], m_rise[2];
    logic         m_chg[2];
    int           m_cnt[2][W];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_s1[k]    = '1;
        m_s2[k]    = '1;
        m_stb[k]   = '1;
        m_fpend[k] = '0;
        m_rpend[k] = '0;
        m_fall[k]  = '0;
        m_rise[k]  = '0;
        m_chg[k]   = 1'b0;
        for (int b = 0; b < W; b++) m_cnt[k][b] = 0;
    endtask

    task automatic model_step(input int k, input logic t, input int dt);
        logic [W-1:0] nf;
        logic [W-1:0] nr;
        nf = '0;
        nr = '0;
        m_fall[k] = m_fpend[k];
        m_rise[k] = m_rpend[k];
        m_chg[k]  = |(m_fpend[k] | m_rpend[k]);
        for (int b = 0; b < W; b++) begin
            if (m_s2[k][b] == m_stb[k][b]) begin
                m_cnt[k][b] = 0;
            end else if (t) begin
                if (m_cnt[k][b] == dt - 1) begin
                    if (m_s2[k][b] == 1'b0) nf[b] = 1'b1;
                    else                    nr[b] = 1'b1;
                    m_stb[k][b] = m_s2[k][b];
                    m_cnt[k][b] = 0;
                end else begin
                    m_cnt[k][b] = m_cnt[k][b] + 1;
                end
            end
        end
        m_fpend[k] = nf;
        m_rpend[k] = nr;
        m_s2[k]    = m_s1[k];
        m_s1[k]    = pins;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, tick4, 4);
            model_step(1, tick3, 3);
        end
        q4.push_back('{port_in: m_stb[0], fall: m_fall[0], rise: m_rise[0], chg: m_chg[0]});
        q3.push_back('{port_in: m_stb[1], fall: m_fall[1], rise: m_rise[1], chg: m_chg[1]});
    end

    // Advance one clock, compare both DUTs against the newest expectation, then set tick3.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        check_val("sb_has_exp", (q4.size() > 0) && (q3.size() > 0), 1);
        if (q4.size() > 0) begin
            e = q4[$];
            q4.delete();
            check_val("u4_port_in", port_in4, e.port_in);
            check_val("u4_irq_fall", irq_fall4, e.fall);
            check_val("u4_changed", changed4, e.chg);
`ifdef PORT_INPUT_RISE_IRQ_EN
            check_val("u4_irq_rise", irq_rise4, e.rise);
`endif
        end
        if (q3.size() > 0) begin
            e = q3[$];
            q3.delete();
            check_val("u3_port_in", port_in3, e.port_in);
            check_val("u3_irq_fall", irq_fall3, e.fall);
            check_val("u3_changed", changed3, e.chg);
`ifdef PORT_INPUT_RISE_IRQ_EN
            check_val("u3_irq_rise", irq_rise3, e.rise);
`endif
        end
        tick_div = (tick_div + 1) % 10;
        tick3    = (tick_div == 0);
    endtask

    task automatic run_watch(input int n, output int t_port, output int t_irq,
                             output logic [W-1:0] irq_v, output int t_chg, output int n_irq);
        logic [W-1:0] base;
        base   = port_in4;
        t_port = -1;
        t_irq  = -1;
        t_chg  = -1;
        n_irq  = 0;
        irq_v  = '0;
        for (int i = 1; i <= n; i++) begin
            cyc();
            if (t_port < 0 && port_in4 !== base) t_port = i;
            if (irq_fall4 != '0) begin
                n_irq++;
                if (t_irq < 0) begin
                    t_irq = i;
                    irq_v = irq_fall4;
                end
            end
            if (t_chg < 0 && changed4) t_chg = i;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int           tp, ti, tc, nf, nt, exp_edge, bounce_irq;
        logic         t_at, moved;
        logic [W-1:0] iv, base;

        // Reset with all pins low: outputs idle high, low accepted only after full debounce
        pins    = 4'b0000;
        reset_n = 1'b0;
        repeat (3) cyc();
        check_val("a_reset_port_in", port_in4, 4'hF);
        check_val("a_reset_irq", irq_fall4, 4'h0);
        check_val("a_reset_changed", changed4, 1'b0);
        reset_n = 1'b1;
        run_watch(10, tp, ti, iv, tc, nf);
        check_val("a_port_latency", tp, 6);
        check_val("a_irq_latency", ti, 7);
        check_val("a_irq_value", iv, 4'hF);
        check_val("a_changed_latency", tc, 7);
        check_val("a_irq_pulses", nf, 1);
        check_val("a_port_final", port_in4, 4'h0);

        // Single bit fall
        pins = 4'hF;
        repeat (45) cyc();
        check_val("b_settled_high", port_in4, 4'hF);
        pins = 4'b1011;
        run_watch(10, tp, ti, iv, tc, nf);
        check_val("b_port_latency", tp, 6);
        check_val("b_irq_latency", ti, 7);
        check_val("b_irq_value", iv, 4'b0100);
        check_val("b_irq_pulses", nf, 1);
        check_val("b_port_final", port_in4, 4'b1011);

        // Bounce on bit 1: 0,1,0,1,0,1 two clocks each, then settle low
        pins = 4'hF;
        repeat (45) cyc();
        moved      = 1'b0;
        bounce_irq = 0;
        for (int p = 0; p < 6; p++) begin
            pins[1] = p[0];
            repeat (2) begin
                cyc();
                if (port_in4 !== 4'hF) moved = 1'b1;
                if (irq_fall4 != '0) bounce_irq++;
            end
        end
        check_val("c_bounce_hold", moved, 1'b0);
        check_val("c_bounce_no_irq", bounce_irq, 0);
        pins[1] = 1'b0;
        run_watch(10, tp, ti, iv, tc, nf);
        check_val("c_port_latency", tp, 6);
        check_val("c_irq_latency", ti, 7);
        check_val("c_irq_value", iv, 4'b0010);
        check_val("c_irq_pulses", nf, 1);

        // Slow tick on the DEBOUNCE_TICKS=3 instance: commit on the 3rd tick after s2 changes
        pins = 4'hF;
        repeat (45) cyc();
        check_val("d_settled_high", port_in3, 4'hF);
        pins[0]  = 1'b0;
        nt       = 0;
        exp_edge = -1;
        tp       = -1;
        base     = port_in3;
        for (int i = 1; i <= 60; i++) begin
            t_at = tick3;
            cyc();
            if (i >= 3 && t_at) begin
                nt++;
                if (nt == 3) exp_edge = i;
            end
            if (tp < 0 && port_in3 !== base) tp = i;
        end
        check_val("d_commit_edge", tp, exp_edge);
        check_val("d_port_final", port_in3, 4'b1110);

        // Reset while bit 3 is pending with count 2
        pins = 4'b1110;
        repeat (45) cyc();
        check_val("e_pre_port_in", port_in4, 4'b1110);
        pins[3] = 1'b0;
        repeat (4) cyc();
        #2 reset_n = 1'b0;
        #1;
        check_val("e_async_port_in", port_in4, 4'hF);
        check_val("e_async_irq", irq_fall4, 4'h0);
        repeat (2) cyc();
        reset_n = 1'b1;
        run_watch(10, tp, ti, iv, tc, nf);
        check_val("e_port_latency", tp, 6);
        check_val("e_irq_latency", ti, 7);
        check_val("e_irq_value", iv, 4'b1001);
        check_val("e_irq_pulses", nf, 1);

        // Rise on bit 0: changed pulses, no fall pulse
        pins = 4'b0111;
        begin
            int tr;
            logic [W-1:0] rv;
            tr = -1;
            rv = '0;
            run_watch(10, tp, ti, iv, tc, nf);
            check_val("f_port_latency", tp, 6);
            check_val("f_changed_latency", tc, 7);
            check_val("f_no_fall", nf, 0);
            check_val("f_port_final", port_in4, 4'b0111);
`ifdef PORT_INPUT_RISE_IRQ_EN
            pins = 4'b0110;
            repeat (12) cyc();
            pins = 4'b0111;
            for (int i = 1; i <= 10; i++) begin
                cyc();
                if (tr < 0 && irq_rise4 != '0) begin
                    tr = i;
                    rv = irq_rise4;
                end
            end
            check_val("f_rise_latency", tr, 7);
            check_val("f_rise_value", rv, 4'b0001);
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
